// File: rtl/tea_pkg.sv
// rtl/tea_pkg.sv - shared constants, enums and sum seed helper for the TEA/XTEA engine
package tea_pkg;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  typedef enum logic {ALGO_TEA, ALGO_XTEA} algo_e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Both algorithms start decryption from DELTA*rounds; folded to a constant at elaboration.
  function automatic logic [31:0] sum_init(input algo_e algo, input logic decrypt, input int rounds);
    logic [31:0] s;
    s = 32'd0;
    case (algo)
      ALGO_TEA, ALGO_XTEA: begin
        if (decrypt) begin
          for (int i = 0; i < rounds; i++) s = s + DELTA;
        end
      end
      default: s = 32'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tea_round.sv
// rtl/tea_round.sv - one combinational TEA or XTEA cipher cycle (both halves, sum update)
module tea_round
  import tea_pkg::*;
#(
  parameter algo_e ALGO = ALGO_TEA
) (
  input  logic [31:0]  v0,
  input  logic [31:0]  v1,
  input  logic [31:0]  sum,
  input  logic [127:0] key,
  input  logic         decrypt,
  output logic [31:0]  v0_o,
  output logic [31:0]  v1_o,
  output logic [31:0]  sum_o
);

  logic [31:0] k [4];
  assign k[0] = key[127:96];
  assign k[1] = key[95:64];
  assign k[2] = key[63:32];
  assign k[3] = key[31:0];

  logic [31:0] a, b, s;

  always_comb begin
    a = v0;
    b = v1;
    s = sum;
    if (ALGO == ALGO_TEA) begin
      if (!decrypt) begin
        s = sum + DELTA;
        a = v0 + (((v1 << 4) + k[0]) ^ (v1 + s) ^ ((v1 >> 5) + k[1]));
        b = v1 + (((a << 4) + k[2]) ^ (a + s) ^ ((a >> 5) + k[3]));
      end else begin
        b = v1 - (((v0 << 4) + k[2]) ^ (v0 + sum) ^ ((v0 >> 5) + k[3]));
        a = v0 - (((b << 4) + k[0]) ^ (b + sum) ^ ((b >> 5) + k[1]));
        s = sum - DELTA;
      end
    end else begin
      if (!decrypt) begin
        a = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]));
        s = sum + DELTA;
        b = v1 + ((((a << 4) ^ (a >> 5)) + a) ^ (s + k[s[12:11]]));
      end else begin
        b = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]));
        s = sum - DELTA;
        a = v0 - ((((b << 4) ^ (b >> 5)) + b) ^ (s + k[s[1:0]]));
      end
    end
  end

  assign v0_o  = a;
  assign v1_o  = b;
  assign sum_o = s;

endmodule

// File: rtl/tea_cipher_engine.sv
// rtl/tea_cipher_engine.sv - stream-attached TEA/XTEA engine, one 64-bit block in flight
module tea_cipher_engine
  import tea_pkg::*;
#(
  parameter algo_e ALGO   = ALGO_TEA,
  parameter int    ROUNDS = 32,
  parameter int    RPC    = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [127:0] i_key,
  input  logic         i_axis_valid_s,
  output logic         o_axis_ready_s,
  input  logic [63:0]  i_axis_data_s,
  input  logic         i_axis_user_s,
  input  logic         i_axis_last_s,
  output logic         o_axis_valid_m,
  input  logic         i_axis_ready_m,
  output logic [63:0]  o_axis_data_m,
  output logic         o_axis_last_m,
  output logic         o_busy
);

  localparam int N  = ROUNDS / RPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [31:0] SUM_ENC = sum_init(ALGO, 1'b0, ROUNDS);
  localparam logic [31:0] SUM_DEC = sum_init(ALGO, 1'b1, ROUNDS);

  if ((ROUNDS < 1) || (ROUNDS > 64) || !((RPC == 1) || (RPC == 2) || (RPC == 4)) ||
      ((ROUNDS % RPC) != 0)) begin : g_param_check
    $error("tea_cipher_engine: ROUNDS must be 1..64, RPC in {1,2,4} and divide ROUNDS");
  end

  state_e        state_q, state_d;
  logic [31:0]   v0_q, v1_q, sum_q;
  logic [127:0]  key_q;
  logic          dec_q, last_q;
  logic [CW-1:0] cnt_q;
  logic          load, finish;

  // Round chain: stage i feeds stage i+1, the last stage writes back into the state registers.
  logic [31:0] c_v0 [RPC+1];
  logic [31:0] c_v1 [RPC+1];
  logic [31:0] c_sum [RPC+1];

  assign c_v0[0]  = v0_q;
  assign c_v1[0]  = v1_q;
  assign c_sum[0] = sum_q;

  for (genvar i = 0; i < RPC; i++) begin : g_round
    tea_round #(.ALGO(ALGO)) u_round (
      .v0     (c_v0[i]),
      .v1     (c_v1[i]),
      .sum    (c_sum[i]),
      .key    (key_q),
      .decrypt(dec_q),
      .v0_o   (c_v0[i+1]),
      .v1_o   (c_v1[i+1]),
      .sum_o  (c_sum[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_axis_valid_s) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_axis_ready_m) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      v0_q          <= 32'd0;
      v1_q          <= 32'd0;
      sum_q         <= 32'd0;
      key_q         <= 128'd0;
      dec_q         <= 1'b0;
      last_q        <= 1'b0;
      cnt_q         <= '0;
      o_axis_data_m <= 64'd0;
      o_axis_last_m <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        v0_q   <= i_axis_data_s[63:32];
        v1_q   <= i_axis_data_s[31:0];
        key_q  <= i_key;
        dec_q  <= i_axis_user_s;
        last_q <= i_axis_last_s;
        sum_q  <= i_axis_user_s ? SUM_DEC : SUM_ENC;
        cnt_q  <= '0;
      end else if (state_q == RUN) begin
        v0_q  <= c_v0[RPC];
        v1_q  <= c_v1[RPC];
        sum_q <= c_sum[RPC];
        cnt_q <= cnt_q + CW'(1);
        if (finish) begin
          o_axis_data_m <= {c_v0[RPC], c_v1[RPC]};
          o_axis_last_m <= last_q;
        end
      end
    end
  end

  assign o_axis_ready_s = (state_q == IDLE);
  assign o_axis_valid_m = (state_q == DONE);
  assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_tea_cipher_engine.sv
// tb/tb_tea_cipher_engine.sv - scoreboard bench for a TEA/RPC=1 and an XTEA/RPC=4 engine
module tb_tea_cipher_engine;
  import tea_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][127:0] key_s;
  logic [1:0]        valid_s, ready_s, user_s, last_s;
  logic [1:0][63:0]  data_s;
  logic [1:0]        valid_m, ready_m, last_m, busy;
  logic [1:0][63:0]  data_m;

  tea_cipher_engine #(.ALGO(ALGO_TEA), .ROUNDS(32), .RPC(1)) u_tea (
    .i_clk(clk), .i_rst(rst), .i_key(key_s[0]),
    .i_axis_valid_s(valid_s[0]), .o_axis_ready_s(ready_s[0]), .i_axis_data_s(data_s[0]),
    .i_axis_user_s(user_s[0]), .i_axis_last_s(last_s[0]),
    .o_axis_valid_m(valid_m[0]), .i_axis_ready_m(ready_m[0]), .o_axis_data_m(data_m[0]),
    .o_axis_last_m(last_m[0]), .o_busy(busy[0])
  );

  tea_cipher_engine #(.ALGO(ALGO_XTEA), .ROUNDS(32), .RPC(4)) u_xtea (
    .i_clk(clk), .i_rst(rst), .i_key(key_s[1]),
    .i_axis_valid_s(valid_s[1]), .o_axis_ready_s(ready_s[1]), .i_axis_data_s(data_s[1]),
    .i_axis_user_s(user_s[1]), .i_axis_last_s(last_s[1]),
    .o_axis_valid_m(valid_m[1]), .i_axis_ready_m(ready_m[1]), .o_axis_data_m(data_m[1]),
    .o_axis_last_m(last_m[1]), .o_busy(busy[1])
  );

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int acc_cyc [2];
  logic [64:0] q0 [$];
  logic [64:0] q1 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model written from the published C routines.
  function automatic logic [63:0] ref_model(input logic [63:0] blk, input logic [127:0] key,
                                            input logic dec, input logic xtea);
    logic [31:0] v0, v1, s;
    logic [31:0] k [4];
    k[0] = key[127:96]; k[1] = key[95:64]; k[2] = key[63:32]; k[3] = key[31:0];
    v0 = blk[63:32];
    v1 = blk[31:0];
    s  = dec ? 32'hC6EF3720 : 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (!xtea && !dec) begin
        s  += 32'h9E3779B9;
        v0 += ((v1 << 4) + k[0]) ^ (v1 + s) ^ ((v1 >> 5) + k[1]);
        v1 += ((v0 << 4) + k[2]) ^ (v0 + s) ^ ((v0 >> 5) + k[3]);
      end else if (!xtea) begin
        v1 -= ((v0 << 4) + k[2]) ^ (v0 + s) ^ ((v0 >> 5) + k[3]);
        v0 -= ((v1 << 4) + k[0]) ^ (v1 + s) ^ ((v1 >> 5) + k[1]);
        s  -= 32'h9E3779B9;
      end else if (!dec) begin
        v0 += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + k[s & 3]);
        s  += 32'h9E3779B9;
        v1 += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + k[(s >> 11) & 3]);
      end else begin
        v1 -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + k[(s >> 11) & 3]);
        s  -= 32'h9E3779B9;
        v0 -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + k[s & 3]);
      end
    end
    return {v0, v1};
  endfunction

  task automatic monitor();
    logic [1:0] vprev = 2'b00;
    logic [64:0] exp;
    forever begin
      @(negedge clk);
      if (rst) vprev = 2'b00;
      else begin
        for (int d = 0; d < 2; d++) begin
          if (valid_m[d] && !vprev[d])
            chk($sformatf("latency_d%0d", d), 65'(cyc - acc_cyc[d]), 65'((d == 0) ? 32 : 8));
          vprev[d] = valid_m[d];
          if (valid_m[d] && ready_m[d]) begin
            if (((d == 0) ? q0.size() : q1.size()) == 0) begin
              ntests++; nfail++;
              $display("FAIL unexpected_out_d%0d: got %h with empty scoreboard", d, data_m[d]);
            end else begin
              exp = (d == 0) ? q0.pop_front() : q1.pop_front();
              chk($sformatf("out_d%0d", d), {last_m[d], data_m[d]}, exp);
            end
          end
        end
      end
    end
  endtask

  task automatic send(input int d, input logic [63:0] data, input logic [127:0] key,
                      input logic user, input logic last, input logic [63:0] exp);
    int budget = 200;
    logic acc = 1'b0;
    valid_s[d] = 1'b1; data_s[d] = data; key_s[d] = key; user_s[d] = user; last_s[d] = last;
    if (d == 0) q0.push_back({last, exp}); else q1.push_back({last, exp});
    while (!acc && budget > 0) begin
      @(negedge clk); acc = ready_s[d];
      @(posedge clk); #1; budget--;
    end
    valid_s[d] = 1'b0;
    chk($sformatf("accept_d%0d", d), 65'(acc), 65'(1));
    acc_cyc[d] = cyc;
  endtask

  task automatic drain(input int d);
    int budget = 400;
    while ((((d == 0) ? q0.size() : q1.size()) != 0) && budget > 0) begin
      @(posedge clk); #1; budget--;
    end
    chk($sformatf("drain_d%0d", d), 65'(budget > 0), 65'(1));
  endtask

  initial begin
    logic [63:0] p, c;
    logic [127:0] kk;
    int bud, prev;
    valid_s = '0; user_s = '0; last_s = '0; data_s = '0; key_s = '0; ready_m = 2'b11;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    fork
      monitor();
      begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      chk("rst_ready_s", 65'(ready_s[d]), 65'(1));
      chk("rst_valid_m", 65'(valid_m[d]), 65'(0));
      chk("rst_data_m", 65'(data_m[d]), 65'(0));
      chk("rst_last_m", 65'(last_m[d]), 65'(0));
      chk("rst_busy", 65'(busy[d]), 65'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Published zero-key/zero-data vectors, forward and back.
    send(0, 64'h0, 128'h0, 1'b0, 1'b1, 64'h41EA3A0A_94BAA940);
    drain(0);
    send(0, 64'h41EA3A0A_94BAA940, 128'h0, 1'b1, 1'b0, 64'h0);
    drain(0);
    send(1, 64'h0, 128'h0, 1'b0, 1'b0, 64'hDEE9D4D8_F7131ED9);
    drain(1);
    send(1, 64'hDEE9D4D8_F7131ED9, 128'h0, 1'b1, 1'b1, 64'h0);
    drain(1);

    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < 2; d++) begin
        p  = {$urandom, $urandom};
        kk = {$urandom, $urandom, $urandom, $urandom};
        c  = ref_model(p, kk, 1'b0, d == 1);
        send(d, p, kk, 1'b0, 1'($urandom_range(0, 1)), c);
        drain(d);
        send(d, c, kk, 1'b1, 1'($urandom_range(0, 1)), p);
        drain(d);
      end
    end

    // Backpressure in DONE while input side is scrambled.
    ready_m[0] = 1'b0;
    send(0, 64'h0, 128'h0, 1'b0, 1'b1, 64'h41EA3A0A_94BAA940);
    bud = 100;
    while (bud > 0) begin
      @(negedge clk);
      if (valid_m[0]) break;
      @(posedge clk); #1;
      key_s[0] = {4{$urandom}}; data_s[0] = {$urandom, $urandom};
      valid_s[0] = 1'b1; user_s[0] = 1'b1; last_s[0] = 1'b0;
      bud--;
    end
    chk("bp_valid_rise", 65'(valid_m[0]), 65'(1));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      key_s[0] = {4{$urandom}}; data_s[0] = {$urandom, $urandom}; valid_s[0] = 1'($urandom);
      @(negedge clk);
      chk("bp_valid_m", 65'(valid_m[0]), 65'(1));
      chk("bp_data_m", 65'(data_m[0]), 65'(64'h41EA3A0A_94BAA940));
      chk("bp_last_m", 65'(last_m[0]), 65'(1));
      chk("bp_ready_s", 65'(ready_s[0]), 65'(0));
    end
    @(posedge clk); #1;
    valid_s[0] = 1'b0;
    ready_m[0] = 1'b1;
    drain(0);

    // Back-to-back: valid stays up and the next block enters every N+2 cycles.
    for (int d = 0; d < 2; d++) begin
      prev = 0;
      for (int i = 0; i < 4; i++) begin
        p  = {$urandom, $urandom};
        kk = {$urandom, $urandom, $urandom, $urandom};
        send(d, p, kk, 1'b0, 1'(i % 2), ref_model(p, kk, 1'b0, d == 1));
        if (i > 0) chk($sformatf("b2b_period_d%0d", d), 65'(acc_cyc[d] - prev), 65'((d == 0) ? 34 : 10));
        prev = acc_cyc[d];
      end
      drain(d);
    end

    // Reset while counter is 10: in-flight block is dropped.
    send(0, 64'h0123_4567_89AB_CDEF, 128'h1, 1'b0, 1'b1, 64'h0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    @(negedge clk);
    chk("mid_rst_ready_s", 65'(ready_s[0]), 65'(1));
    chk("mid_rst_valid_m", 65'(valid_m[0]), 65'(0));
    chk("mid_rst_data_m", 65'(data_m[0]), 65'(0));
    chk("mid_rst_busy", 65'(busy[0]), 65'(0));
    @(posedge clk); #1;
    send(0, 64'h0, 128'h0, 1'b0, 1'b0, 64'h41EA3A0A_94BAA940);
    drain(0);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/tea_cipher_engine.md
Name: tea_cipher_engine

Overview:
- Parametrised successor TEA/XTEA block cipher engine for the crypto accelerator datapath.
- Encrypts or decrypts one 64-bit block per transaction under a 128-bit key.
- Mode is selected per block; algorithm and rounds-per-clock are elaboration-time choices.
- Sits between an upstream AXI-Stream producer and a downstream AXI-Stream consumer, with one block in flight.

Parameters:
- ALGO, ALGO_TEA: ALGO_TEA or ALGO_XTEA (tea_pkg enum).
- ROUNDS, 32: cipher cycles per block. Each cycle updates both v0 and v1. Range 1..64.
- RPC, 1: cycles unrolled per clock. Allowed values 1, 2, 4. ROUNDS % RPC == 0, checked by an elaboration assertion.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_key  in  128  key. k[0]=i_key[127:96] … k[3]=i_key[31:0]. Sampled only at input handshake.
- i_axis_valid_s  in  1  upstream block valid
- o_axis_ready_s  out  1  engine can accept a block
- i_axis_data_s  in  64  block; v0=[63:32], v1=[31:0]
- i_axis_user_s  in  1  0=encrypt, 1=decrypt
- i_axis_last_s  in  1  packet last flag, passed through
- o_axis_valid_m  out  1  result valid
- i_axis_ready_m  in  1  downstream accepts result
- o_axis_data_m  out  64  result {v0,v1}
- o_axis_last_m  out  1  last flag of the block in flight
- o_busy  out  1  high while state != IDLE

Behaviour:
- Reset (i_rst high at edge, regardless of state): state=IDLE, o_axis_ready_s=1, o_axis_valid_m=0, o_axis_data_m=0, o_axis_last_m=0, o_busy=0.
  - All internal v/sum/key/counter registers are cleared.
  - A block in flight is discarded.
- Let N = ROUNDS/RPC. Counter width is $clog2(N), minimum 1.
- FSM states: IDLE, RUN, DONE (tea_pkg).
- IDLE:
  - o_axis_ready_s=1.
  - On valid&&ready edge, capture data into v0/v1, i_key into k[], mode, last; set sum and counter=0; go to RUN.
  - Capture happens on the handshake edge itself; there is no separate load cycle.
  - o_axis_ready_s drops to 0 on that edge.
- RUN:
  - Each edge applies RPC cycles through a chain of RPC tea_round instances and increments the counter.
  - On the edge where counter==N-1: go to DONE, o_axis_valid_m<=1, o_axis_data_m<={v0,v1} final, o_axis_last_m<=captured last.
  - Inputs are ignored in RUN.
- Latency: o_axis_valid_m is high exactly N edges after the accepting edge (default 32).
- DONE:
  - o_axis_valid_m stays 1 and data/last stay stable until i_axis_ready_m=1.
  - On the handshake edge: o_axis_valid_m<=0, o_axis_ready_s<=1, go to IDLE.
  - o_axis_data_m holds its last value after the handshake.
- Throughput: a new block can be accepted on the edge after the output handshake. Minimum period is N+2 cycles.
- sum initial value:
  - Encrypt: 0.
  - TEA decrypt: DELTA*ROUNDS mod 2^32.
  - XTEA decrypt: DELTA*ROUNDS mod 2^32.
  - Computed as a constant, not with a runtime multiplier.
- All arithmetic is modulo 2^32. Shifts are logical. DELTA=32'h9E3779B9.
- TEA encrypt (one cycle):
  - sum+=DELTA
  - v0+=((v1<<4)+k0)^(v1+sum)^((v1>>5)+k1)
  - v1+=((v0<<4)+k2)^(v0+sum)^((v0>>5)+k3), using the updated v0.
- TEA decrypt (one cycle):
  - v1-=((v0<<4)+k2)^(v0+sum)^((v0>>5)+k3)
  - v0-=((v1<<4)+k0)^(v1+sum)^((v1>>5)+k1)
  - sum-=DELTA
- XTEA encrypt (one cycle):
  - v0+=(((v1<<4)^(v1>>5))+v1)^(sum+k[sum[1:0]])
  - sum+=DELTA
  - v1+=(((v0<<4)^(v0>>5))+v0)^(sum+k[sum[12:11]])
- XTEA decrypt: the exact inverse order of XTEA encrypt.
- Changes on i_key or i_axis_user_s after acceptance have no effect on the block in flight.
- Simultaneous i_rst and handshake: reset wins.

Decomposition:
- tea_pkg holds:
  - DELTA
  - algo_e {ALGO_TEA, ALGO_XTEA}
  - state_e {IDLE, RUN, DONE}
  - function sum_init(algo, decrypt, rounds)
- Sub-module tea_round is purely combinational, one cipher cycle:
  - Parameter ALGO.
  - Inputs: v0, v1, sum, k[4], decrypt.
  - Outputs: v0', v1', sum'.
  - Instantiated RPC times in a chain by tea_cipher_engine.

Test Plan:
- TEA, ROUNDS=32, RPC=1, key=0, data=0, encrypt -> o_axis_data_m=64'h41EA3A0A_94BAA940, with valid exactly 32 edges after the accept edge.
- Same configuration, decrypt of 64'h41EA3A0A_94BAA940 with key=0 -> 64'h0. Repeat with random key/data for 1000 blocks: encrypt-then-decrypt must return the original, and results must match the golden C model.
- XTEA, ROUNDS=32, key=0, data=0 encrypt -> 64'hDEE9D4D8_F7131ED9, matching the C model. Rerun with RPC=2 and RPC=4: same result, with latency 16 and 8 edges.
- Backpressure: hold i_axis_ready_m=0 for 20 cycles in DONE -> o_axis_valid_m, data, and last stay stable and o_axis_ready_s=0. Toggling i_key or i_axis_valid_s during RUN/DONE must not change the result.
- Back-to-back: upstream valid is always high and downstream ready is always high -> blocks are accepted every N+2 cycles. The last flag of each output matches its input.
- Reset mid-RUN at counter=10 -> the next edge shows o_axis_ready_s=1, o_axis_valid_m=0, o_axis_data_m=0, o_busy=0. A subsequent block then encrypts correctly.
